// File: rtl/expand_key_iter_if.sv
// Round-key stream from the key-schedule engine to its consumer.
interface expand_key_iter_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  modport master (
    output rk_valid, rk_out, rk_idx,
    input  rk_ready
  );

  modport slave (
    input  rk_valid, rk_out, rk_idx,
    output rk_ready
  );
endinterface

// File: rtl/expand_key_iter.sv
// Iterative AES-128/256 key schedule: one round key per handshake,
// sharing a single registered SubWord stage across all rounds.
module expand_key_iter #(
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              key_len,
  input  logic [255:0]      key_in,
  output logic              busy,
  output logic              done,
  expand_key_iter_if.master rk
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OUT  = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] GEN  = 2'd3;

  logic [1:0]       state;
  logic             mode256;
  logic [7:0]       rcon;
  logic [127:0]     rk_q;
  logic [3:0]       idx_q;
  logic [31:0]      s4_q;
  logic [31:0]      win [8];
  logic [7:0][31:0] kw;

  logic        m256;
  logic        hs;
  logic        rot;
  logic [3:0]  last;
  logic [31:0] w_last;
  logic [31:0] s4_d;
  logic [31:0] t;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] n0, n1, n2, n3;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 is the product of x^(2^k), k=1..7.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  assign kw     = key_in;
  assign m256   = key_len & SUPPORT_256;
  assign hs     = (state == OUT) && rk.rk_ready;
  assign last   = mode256 ? 4'd14 : 4'd10;
  assign rot    = !mode256 || idx_q[0];
  assign w_last = win[7];
  assign s4_d   = rot ? {w_last[23:0], w_last[31:24]} : w_last;
  assign t      = s4_q ^ (rot ? {rcon, 24'h0} : 32'h0);

  // The window holds the newest words at win[4..7]; AES-256 also uses win[0..3].
  assign p0 = mode256 ? win[0] : win[4];
  assign p1 = mode256 ? win[1] : win[5];
  assign p2 = mode256 ? win[2] : win[6];
  assign p3 = mode256 ? win[3] : win[7];
  assign n0 = p0 ^ t;
  assign n1 = p1 ^ n0;
  assign n2 = p2 ^ n1;
  assign n3 = p3 ^ n2;

  assign rk.rk_valid = (state == OUT);
  assign rk.rk_out   = rk_q;
  assign rk.rk_idx   = idx_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode256 <= 1'b0;
      rcon    <= 8'h01;
      rk_q    <= '0;
      idx_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          if (start) begin
            mode256 <= m256;
            rk_q    <= key_in[255:128];
            idx_q   <= 4'd0;
            rcon    <= 8'h01;
            state   <= OUT;
          end
        end
        state == OUT: begin
          if (hs) begin
            if (idx_q == last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (mode256 && idx_q == 4'd0) begin
              rk_q  <= {win[4], win[5], win[6], win[7]};
              idx_q <= 4'd1;
            end else begin
              state <= SUB;
            end
          end
        end
        state == SUB: state <= GEN;
        state == GEN: begin
          rk_q  <= {n0, n1, n2, n3};
          idx_q <= idx_q + 4'd1;
          if (rot) rcon <= xt(rcon);
          state <= OUT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < 8; i++) win[i] <= kw[7-i];
      if (!m256) begin
        for (int i = 0; i < 4; i++) win[4+i] <= kw[7-i];
      end
    end
    if (state == SUB) s4_q <= subword(s4_d);
    if (state == GEN) begin
      if (mode256) begin
        for (int i = 0; i < 4; i++) win[i] <= win[i+4];
      end
      win[4] <= n0;
      win[5] <= n1;
      win[6] <= n2;
      win[7] <= n3;
    end
  end

endmodule

// File: tb/tb_expand_key_iter.sv
// Directed bench for expand_key_iter: FIPS-197 AES-128/256 schedules,
// cycle timing, backpressure, reset, SUPPORT_256=0 and back-to-back runs.
module tb_expand_key_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start2;
  logic         key_len;
  logic [255:0] key_in;
  logic         busy, done, busy2, done2;

  expand_key_iter_if rk_if ();
  expand_key_iter_if rk2_if ();

  expand_key_iter dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .key_in(key_in), .busy(busy), .done(done), .rk(rk_if.master)
  );

  expand_key_iter #(.SUPPORT_256(1'b0)) dut128 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len),
    .key_in(key_in), .busy(busy2), .done(done2), .rk(rk2_if.master)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] e128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] e256 [15] = '{
    128'h603deb1015ca71be2b73aef0857d7781,
    128'h1f352c073b6108d72d9810a30914dff4,
    128'h9ba354118e6925afa51a8b5f2067fcde,
    128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'hd59aecb85bf3c917fee94248de8ebe96,
    128'hb5a9328a2678a647983122292f6c79b3,
    128'h812c81addadf48ba24360af2fab8b464,
    128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h68007bacb2df331696e939e46c518d80,
    128'hc814e20476a9fb8a5025c02d59c58239,
    128'hde1369676ccc5a71fa2563959674ee15,
    128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'h749c47ab18501ddae2757e4f7401905a,
    128'hcafaaae3e4d59b349adf6acebd10190d,
    128'hfe4890d1e6188d0b046df344706c631e
  };

  function automatic logic [127:0] exp_key(input bit m256, input int n);
    if (m256) return (n >= 0 && n <= 14) ? e256[n] : 'x;
    return (n >= 0 && n <= 10) ? e128[n] : 'x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    key_len = 1'b0; key_in = '0;
    rk_if.rk_ready = 1'b0; rk2_if.rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (rk_if.rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        rk_if.rk_out !== '0 || rk_if.rk_idx !== 4'd0)
      $display("FAIL reset: valid=%b busy=%b done=%b out=%h idx=%0d, expected all zero",
               rk_if.rk_valid, busy, done, rk_if.rk_out, rk_if.rk_idx);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one schedule with rk_ready high, checking values and cycle timing.
  task automatic test_sequence(input bit m256, input bit launched,
                               input int pulse_cyc, input bit chain);
    int n, last, ncyc, ecyc;
    last = m256 ? 14 : 10;
    ncyc = m256 ? 42 : 32;
    rk_if.rk_ready = 1'b1;
    if (!launched) begin
      key_len = m256;
      key_in  = m256 ? KEY256 : {KEY128, 128'h0};
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc == 1) begin
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_c1: busy=%b, expected 1", busy);
        else pass_cnt++;
      end
      if (rk_if.rk_valid) begin
        ecyc = m256 ? ((n == 0) ? 1 : 3 * n - 1) : 1 + 3 * n;
        total_cnt++;
        if (n > last || rk_if.rk_idx !== 4'(n) || rk_if.rk_out !== exp_key(m256, n))
          $display("FAIL key%0d_m%0d: idx=%0d out=%h, expected idx=%0d out=%h",
                   n, m256, rk_if.rk_idx, rk_if.rk_out, n, exp_key(m256, n));
        else pass_cnt++;
        total_cnt++;
        if (cyc != ecyc)
          $display("FAIL time%0d_m%0d: cycle=%0d, expected %0d", n, m256, cyc, ecyc);
        else pass_cnt++;
        n++;
      end
      if (cyc == ncyc - 1) begin
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_early: done=%b, expected 0", done);
        else pass_cnt++;
      end
      if (cyc == ncyc) begin
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0)
          $display("FAIL done_m%0d: done=%b busy=%b, expected done=1 busy=0",
                   m256, done, busy);
        else pass_cnt++;
      end
      if (cyc == pulse_cyc) begin
        start = 1'b1; key_len = ~key_len; key_in = ~key_in;
      end else if (cyc == pulse_cyc + 1) begin
        start = 1'b0;
      end
      if (chain && cyc == ncyc) begin
        key_len = 1'b1; key_in = KEY256; start = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (chain) start = 1'b0;
    total_cnt++;
    if (n != last + 1)
      $display("FAIL count_m%0d: keys=%0d, expected %0d", m256, n, last + 1);
    else pass_cnt++;
  endtask

  task automatic test_aes128();
    test_sequence(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_aes256();
    test_sequence(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure(input bit m256);
    int n, last;
    bit stall, got_done;
    logic [127:0] hold_out;
    logic [3:0]   hold_idx;
    last = m256 ? 14 : 10;
    key_len = m256;
    key_in  = m256 ? KEY256 : {KEY128, 128'h0};
    rk_if.rk_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; stall = 1'b0; got_done = 1'b0;
    hold_out = '0; hold_idx = '0;
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (stall) begin
        total_cnt++;
        if (rk_if.rk_valid !== 1'b1 || rk_if.rk_idx !== hold_idx ||
            rk_if.rk_out !== hold_out)
          $display("FAIL stable_m%0d: valid=%b idx=%0d out=%h, expected 1 %0d %h",
                   m256, rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_out,
                   hold_idx, hold_out);
        else pass_cnt++;
      end
      stall = 1'b0;
      if (done) got_done = 1'b1;
      rk_if.rk_ready = 1'($urandom_range(0, 1));
      if (rk_if.rk_valid) begin
        if (rk_if.rk_ready) begin
          total_cnt++;
          if (n > last || rk_if.rk_idx !== 4'(n) ||
              rk_if.rk_out !== exp_key(m256, n))
            $display("FAIL bp_key%0d_m%0d: idx=%0d out=%h, expected idx=%0d out=%h",
                     n, m256, rk_if.rk_idx, rk_if.rk_out, n, exp_key(m256, n));
          else pass_cnt++;
          n++;
        end else begin
          stall = 1'b1;
          hold_idx = rk_if.rk_idx;
          hold_out = rk_if.rk_out;
        end
      end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!got_done || n != last + 1)
      $display("FAIL bp_end_m%0d: done_seen=%b keys=%0d, expected 1 and %0d",
               m256, got_done, n, last + 1);
    else pass_cnt++;
    rk_if.rk_ready = 1'b1;
  endtask

  task automatic test_support128();
    int n, done_cyc;
    key_len = 1'b1;
    key_in  = {KEY128, 128'hdeadbeef0123456789abcdeffedcba98};
    rk2_if.rk_ready = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (rk2_if.rk_valid) begin
        total_cnt++;
        if (n > 10 || rk2_if.rk_idx !== 4'(n) || rk2_if.rk_out !== exp_key(1'b0, n))
          $display("FAIL s128_key%0d: idx=%0d out=%h, expected idx=%0d out=%h",
                   n, rk2_if.rk_idx, rk2_if.rk_out, n, exp_key(1'b0, n));
        else pass_cnt++;
        n++;
      end
      if (done2 && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (n != 11 || done_cyc != 32)
      $display("FAIL s128_end: keys=%0d done_cycle=%0d, expected 11 and 32",
               n, done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit got_done;
    key_len = 1'b0;
    key_in  = {KEY128, 128'h0};
    rk_if.rk_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    total_cnt++;
    if (rk_if.rk_valid !== 1'b1 || rk_if.rk_idx !== 4'd4)
      $display("FAIL rst_pre: valid=%b idx=%0d, expected 1 and 4",
               rk_if.rk_valid, rk_if.rk_idx);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (rk_if.rk_valid !== 1'b0 || busy !== 1'b0 || rk_if.rk_out !== '0)
      $display("FAIL rst_mid: valid=%b busy=%b out=%h, expected 0 0 0",
               rk_if.rk_valid, busy, rk_if.rk_out);
    else pass_cnt++;
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (rk_if.rk_valid !== 1'b1 || rk_if.rk_out !== e128[0])
      $display("FAIL rst_idx0: valid=%b out=%h, expected 1 %h",
               rk_if.rk_valid, rk_if.rk_out, e128[0]);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (rk_if.rk_valid !== 1'b1 || rk_if.rk_idx !== 4'd1 || rk_if.rk_out !== e128[1])
      $display("FAIL rst_idx1: valid=%b idx=%0d out=%h, expected 1 1 %h",
               rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_out, e128[1]);
    else pass_cnt++;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (!got_done) $display("FAIL rst_drain: done=0, expected 1 within 60 cycles");
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    test_sequence(1'b0, 1'b0, 10, 1'b1);
    test_sequence(1'b1, 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes256();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_support128();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/expand_key_iter.md
# expand_key_iter

Iterative AES key-schedule engine generalising the single-round 128-bit expander to both AES-128 and AES-256 key lengths. A single `start` loads a cipher key. The block then emits every round key in order, from index 0 up to the last round key, over a valid/ready stream. It reuses one registered `S4` SubWord instance for all rounds. It sits between the key-load register and a round-key consumer: the cipher datapath or a round-key RAM writer.

## Interface
- `SUPPORT_256`, default 1: 1 enables the AES-256 schedule. 0 forces the AES-128 schedule and ignores `key_len`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load request; accepted only in IDLE.
- `key_len`  in  1  0 = AES-128, 1 = AES-256; sampled with `start`.
- `key_in`  in  256  cipher key, sampled with `start`. In AES-128 mode only `key_in[255:128]` is used, with w0 in bits [255:224].
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `rk_valid`  out  1  `rk_out` and `rk_idx` are valid.
- `rk_ready`  in  1  consumer accepts the round key.
- `rk_out`  out  128  round key {w[4n], w[4n+1], w[4n+2], w[4n+3]}.
- `rk_idx`  out  4  round-key index n.
- `done`  out  1  one-cycle pulse on the cycle after the last key is accepted.

## Operation
- States: IDLE, OUT, SUB, GEN.
- **IDLE, `start` = 1:**
  - Latch the mode. `mode256 = key_len & SUPPORT_256`.
  - Load the word state. AES-128: w0..w3 from `key_in`. AES-256: w0..w7 from `key_in`.
  - Set `rk_out` = `key_in[255:128]`, `rk_idx` = 0, `rcon` = 0x01. Go to OUT.
- **OUT:** `rk_valid` = 1. `rk_out` and `rk_idx` are held stable until the handshake `rk_valid & rk_ready`. On the handshake:
  - If `rk_idx` is the last index (10 for AES-128, 14 for AES-256): go to IDLE and pulse `done`.
  - If AES-256 and `rk_idx` = 0: set `rk_out` = `key_in[127:0]` (stored copy), `rk_idx` = 1, stay in OUT.
  - Otherwise go to SUB.
- **SUB:** `S4` input = RotWord(w_last), i.e. {w_last[23:0], w_last[31:24]}, for rotating steps, or w_last unrotated for AES-256 odd steps. `S4` registers its output at the end of the cycle.
- **GEN:** t = S4out, XORed with {`rcon`, 24'h0} on rotating steps.
  - New words: n0 = p0 ^ t, n1 = p1 ^ n0, n2 = p2 ^ n1, n3 = p3 ^ n2. p0..p3 are the words 4 positions back in AES-128 and 8 positions back in AES-256.
  - Shift the window. Load `rk_out` = {n0, n1, n2, n3} and `rk_idx` += 1. Go to OUT.
  - On rotating steps, update `rcon` = xtime(`rcon`): shift left by 1, then XOR with 0x1B if the old bit 7 was 1.
- **Step type:** AES-128 steps always rotate. AES-256 steps alternate: round keys 2, 4, …, 14 rotate with `rcon`; round keys 3, 5, …, 13 use SubWord only, with no rcon.
- `start` while not in IDLE is ignored. `key_len` and `key_in` may change freely after acceptance.
- All XORs are bitwise; there is no carry arithmetic. `rcon` is 8 bits wide.
- **Reset:** on `rst` the block goes to IDLE at the next edge, including mid-schedule. Reset values: `rk_valid`, `busy` and `done` = 0; `rk_out` = 0; `rk_idx` = 0; `rcon` = 0x01. Contents of the `S4` pipeline register are don't-care.

## Timing
- `start` is accepted at edge E0. `rk_valid` for index 0 is high in the cycle after E0, and `busy` = 1 from then on.
- Each generated key appears 3 cycles after the previous handshake: SUB, GEN, then OUT.
- The AES-256 index-1 key appears 1 cycle after the index-0 handshake.
- With `rk_ready` tied high, counting the cycle after E0 as cycle 1:
  - AES-128: key n valid in cycle 1 + 3n. Key 10 is in cycle 31; `done` is in cycle 32.
  - AES-256: key 0 in cycle 1; key n ≥ 1 in cycle 3n − 1. Key 14 is in cycle 41; `done` is in cycle 42.
- Backpressure: while `rk_ready` = 0 in OUT, there are no state, word or `rcon` changes.
- `start` is accepted in IDLE in the same cycle `done` is high, so runs can be back-to-back.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready` = 1:
  - idx0 equals the key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 31; `done` in cycle 32.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - idx1 = 1f352c073b6108d72d9810a30914dff4 in cycle 2.
  - idx2 = 9ba354118e6925afa51a8b5f2067fcde.
  - idx14 = fe4890d1e6188d0b046df344706c631e in cycle 41.
- Random `rk_ready` (≈50% duty) on both keys: the same key sequence as above, with `rk_out` and `rk_idx` stable while `rk_valid & !rk_ready`. No index is skipped or duplicated.
- `SUPPORT_256` = 0 with `key_len` = 1 and the AES-128 key in `key_in[255:128]`: the AES-128 sequence is produced and the run ends at idx10.
- `rst` asserted during the SUB of idx5: next cycle `rk_valid` = 0, `busy` = 0 and `rk_out` = 0. A new `start` then reproduces idx1 = a0fafe17….
- `start` pulsed while busy: ignored, and the sequence is unchanged. `start` in the `done` cycle: a second full run begins, with idx0 valid the next cycle.
